// File: rtl/bcd_bin_seq_pkg.sv
// Shared constants for the sequential BCD-to-binary converter: FSM encoding,
// default geometry and the largest legal BCD digit.
package bcd_bin_seq_pkg;

  localparam int unsigned DIGITS_DEF     = 9;
  localparam int unsigned BIN_W_DEF      = 64;
  localparam int unsigned STABLE_CYC_DEF = 16;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_CONV = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  function automatic logic is_bcd_digit(input logic [3:0] nib);
    return nib <= BCD_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_bin_seq_mul10_add.sv
// Combinational acc*10 + digit at BIN_W bits, built from shifts and adds;
// reusable by any decimal radix converter.
module mul10_add #(
  parameter int unsigned BIN_W = 64
) (
  input  logic [BIN_W-1:0] i_acc,
  input  logic [3:0]       i_digit,
  output logic [BIN_W-1:0] o_acc_c
);

  logic [BIN_W-1:0] w_x8;
  logic [BIN_W-1:0] w_x2;

  assign w_x8    = i_acc << 3;
  assign w_x2    = i_acc << 1;
  assign o_acc_c = w_x8 + w_x2 + BIN_W'(i_digit);

endmodule

// File: rtl/bcd_bin_seq.sv
// Debounced, digit-serial BCD-to-binary converter feeding a valid/ready sink.
// Non-decimal nibbles raise digit_err instead of producing a result.
module bcd_bin_seq
  import bcd_bin_seq_pkg::*;
#(
  parameter int unsigned DIGITS     = DIGITS_DEF,
  parameter int unsigned BIN_W      = BIN_W_DEF,
  parameter int unsigned STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  bin_valid,
  output logic                  digit_err,
  output logic                  busy
);

  localparam int unsigned SNAP_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam int unsigned IDX_W  = $clog2(DIGITS + 1);

  logic [1:0]        r_state;
  logic [SNAP_W-1:0] r_snap;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [BIN_W-1:0]  r_acc;
  logic              r_err;
  logic [BIN_W-1:0]  r_bin_out;
  logic              r_bin_valid;
  logic              r_digit_err;
  logic              r_busy;

  logic [1:0]        w_nxt_state;
  logic [SNAP_W-1:0] w_nxt_snap;
  logic [CNT_W-1:0]  w_nxt_cnt;
  logic [IDX_W-1:0]  w_nxt_idx;
  logic [BIN_W-1:0]  w_nxt_acc;
  logic              w_nxt_err;
  logic [BIN_W-1:0]  w_nxt_bin_out;
  logic              w_nxt_bin_valid;
  logic              w_nxt_digit_err;
  logic              w_nxt_busy;

  logic [3:0]        w_digit;
  logic [BIN_W-1:0]  w_acc_step;
  logic              w_err_now;
  logic              w_in_changed;

  // Current digit selected by the MS-first index.
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IDX_W'(i)) w_digit = r_snap[4*i +: 4];
    end
  end

  mul10_add #(.BIN_W(BIN_W)) u_mul10_add (
    .i_acc   (r_acc),
    .i_digit (w_digit),
    .o_acc_c (w_acc_step)
  );

  assign w_err_now    = r_err | ~is_bcd_digit(w_digit);
  assign w_in_changed = (bcd_in != r_snap);

  // Next-state and next-output logic.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_snap      = r_snap;
    w_nxt_cnt       = r_cnt;
    w_nxt_idx       = r_idx;
    w_nxt_acc       = r_acc;
    w_nxt_err       = r_err;
    w_nxt_bin_out   = r_bin_out;
    w_nxt_bin_valid = r_bin_valid;
    w_nxt_digit_err = r_digit_err;
    w_nxt_busy      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_in_changed) begin
          w_nxt_snap  = bcd_in;
          w_nxt_cnt   = '0;
          w_nxt_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_in_changed) begin
          w_nxt_snap = bcd_in;
          w_nxt_cnt  = '0;
        end else if (r_cnt == CNT_W'(STABLE_CYC - 1)) begin
          w_nxt_acc       = '0;
          w_nxt_idx       = IDX_W'(DIGITS - 1);
          w_nxt_err       = 1'b0;
          w_nxt_digit_err = 1'b0;
          w_nxt_state     = ST_CONV;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_CONV: begin
        w_nxt_acc = w_acc_step;
        w_nxt_err = w_err_now;
        if (r_idx == '0) begin
          if (w_err_now) begin
            w_nxt_digit_err = 1'b1;
            w_nxt_state     = ST_IDLE;
          end else begin
            w_nxt_bin_out   = w_acc_step;
            w_nxt_bin_valid = 1'b1;
            w_nxt_state     = ST_HOLD;
          end
        end else begin
          w_nxt_idx = r_idx - IDX_W'(1);
        end
      end
      default: begin
        if (out_ready) begin
          w_nxt_bin_valid = 1'b0;
          w_nxt_state     = ST_IDLE;
        end
      end
    endcase

    w_nxt_busy = (w_nxt_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_snap      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_err       <= 1'b0;
      r_bin_out   <= '0;
      r_bin_valid <= 1'b0;
      r_digit_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_snap      <= w_nxt_snap;
      r_cnt       <= w_nxt_cnt;
      r_idx       <= w_nxt_idx;
      r_acc       <= w_nxt_acc;
      r_err       <= w_nxt_err;
      r_bin_out   <= w_nxt_bin_out;
      r_bin_valid <= w_nxt_bin_valid;
      r_digit_err <= w_nxt_digit_err;
      r_busy      <= w_nxt_busy;
    end
  end

  assign bin_out   = r_bin_out;
  assign bin_valid = r_bin_valid;
  assign digit_err = r_digit_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Self-checking bench for bcd_bin_seq: directed scenarios plus randomized
// entries compared against a digit-by-digit decimal reference model.
module tb_bcd_bin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] bcd_in;
  logic        out_ready;
  logic [63:0] bin_out;
  logic        bin_valid;
  logic        digit_err;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [35:0] last_in;

  always #5 clk = ~clk;

  bcd_bin_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .digit_err (digit_err),
    .busy      (busy)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: plain decimal accumulation over the nine nibbles, MS first.
  function automatic void ref_conv(input logic [35:0] b, output longint unsigned v,
                                   output bit err);
    logic [3:0] nib;
    v   = 0;
    err = 0;
    for (int i = 8; i >= 0; i--) begin
      nib = 4'(b >> (4 * i));
      v   = v * 10 + longint'(nib);
      if (nib > 4'd9) err = 1;
    end
  endfunction

  function automatic logic [35:0] rand_bcd(input bit allow_bad);
    logic [35:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r = r | (36'($urandom_range(0, 9)) << (4 * i));
    if (allow_bad && ($urandom_range(0, 4) == 0))
      r = r | (36'($urandom_range(10, 15)) << (4 * $urandom_range(0, 8)));
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0; bcd_in = '0; out_ready = 1'b0;
    #2;
    tests_run++;
    if ({bin_valid, digit_err, busy, bin_out} !== 67'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b e=%b b=%b out=%0d, want all 0",
               bin_valid, digit_err, busy, bin_out);
    end
    tick(2);
    rst = 1'b1;
    tick(20);
    tests_run++;
    if (busy !== 1'b0 || bin_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_entry_idle: got busy=%b valid=%b, want 0 0", busy, bin_valid);
    end
    last_in = '0;
  endtask

  task automatic test_basic_123();
    bcd_in = 36'h000000123; out_ready = 1'b1;
    tick(25);
    tests_run++;
    if (bin_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_early: got valid=%b busy=%b, want 0 1", bin_valid, busy);
    end
    tick(1);
    tests_run++;
    if (bin_valid !== 1'b1 || bin_out !== 64'd123 || digit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: got valid=%b out=%0d err=%b, want 1 123 0",
               bin_valid, bin_out, digit_err);
    end
    tick(1);
    tests_run++;
    if (bin_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pulse: got valid=%b busy=%b, want 0 0", bin_valid, busy);
    end
    out_ready = 1'b0;
    last_in = bcd_in;
  endtask

  task automatic test_max_hold();
    bit stable_ok;
    bcd_in = 36'h999999999; out_ready = 1'b0;
    tick(26);
    tests_run++;
    if (bin_valid !== 1'b1 || bin_out !== 64'h3B9AC9FF) begin
      tests_failed++;
      $display("FAIL max_result: got valid=%b out=%h, want 1 3b9ac9ff", bin_valid, bin_out);
    end
    stable_ok = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bin_valid !== 1'b1 || bin_out !== 64'h3B9AC9FF || busy !== 1'b1) stable_ok = 0;
    end
    tests_run++;
    if (!stable_ok) begin
      tests_failed++;
      $display("FAIL max_hold_stable: got valid=%b out=%h, want 1 3b9ac9ff held", bin_valid, bin_out);
    end
    out_ready = 1'b1;
    tick(1);
    tests_run++;
    if (bin_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_handshake: got valid=%b busy=%b, want 0 0", bin_valid, busy);
    end
    last_in = bcd_in;
  endtask

  task automatic test_bounce();
    bit quiet;
    out_ready = 1'b1;
    bcd_in = 36'h000000005;
    quiet = 1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (bin_valid !== 1'b0) quiet = 0;
    end
    bcd_in = 36'h000000050;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (bin_valid !== 1'b0) quiet = 0;
    end
    tests_run++;
    if (!quiet) begin
      tests_failed++;
      $display("FAIL bounce_quiet: got an early valid, want none before 26 cycles");
    end
    tick(1);
    tests_run++;
    if (bin_valid !== 1'b1 || bin_out !== 64'd50) begin
      tests_failed++;
      $display("FAIL bounce_result: got valid=%b out=%0d, want 1 50", bin_valid, bin_out);
    end
    tick(1);
    out_ready = 1'b0;
    last_in = bcd_in;
  endtask

  task automatic test_digit_err();
    out_ready = 1'b1;
    bcd_in = 36'h0000000A1;
    tick(25);
    tests_run++;
    if (digit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_early: got err=%b, want 0", digit_err);
    end
    tick(1);
    tests_run++;
    if (digit_err !== 1'b1 || bin_valid !== 1'b0 || bin_out !== 64'd50) begin
      tests_failed++;
      $display("FAIL err_flag: got err=%b valid=%b out=%0d, want 1 0 50", digit_err, bin_valid, bin_out);
    end
    tick(1);
    bcd_in = 36'h000000042;
    tick(16);
    tests_run++;
    if (digit_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got err=%b, want 1 before conversion", digit_err);
    end
    tick(1);
    tests_run++;
    if (digit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: got err=%b, want 0 at conversion start", digit_err);
    end
    tick(9);
    tests_run++;
    if (bin_valid !== 1'b1 || bin_out !== 64'd42) begin
      tests_failed++;
      $display("FAIL err_recover: got valid=%b out=%0d, want 1 42", bin_valid, bin_out);
    end
    tick(1);
    out_ready = 1'b0;
    last_in = bcd_in;
  endtask

  task automatic test_change_in_hold();
    out_ready = 1'b0;
    bcd_in = 36'h000000007;
    tick(26);
    bcd_in = 36'h000000008;
    tick(5);
    tests_run++;
    if (bin_valid !== 1'b1 || bin_out !== 64'd7) begin
      tests_failed++;
      $display("FAIL hold_ignore: got valid=%b out=%0d, want 1 7", bin_valid, bin_out);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(25);
    tests_run++;
    if (bin_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_next_early: got valid=%b, want 0", bin_valid);
    end
    tick(1);
    tests_run++;
    if (bin_valid !== 1'b1 || bin_out !== 64'd8) begin
      tests_failed++;
      $display("FAIL hold_next: got valid=%b out=%0d, want 1 8", bin_valid, bin_out);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    last_in = bcd_in;
  endtask

  task automatic test_reset_mid_conv();
    longint unsigned v;
    bit e;
    bcd_in = 36'h123456789;
    ref_conv(bcd_in, v, e);
    tick(20);
    rst = 1'b0;
    #1;
    tests_run++;
    if (bin_valid !== 1'b0 || busy !== 1'b0 || bin_out !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got valid=%b busy=%b out=%0d, want 0 0 0", bin_valid, busy, bin_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(25);
    tests_run++;
    if (bin_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_restart_early: got valid=%b busy=%b, want 0 1", bin_valid, busy);
    end
    tick(1);
    tests_run++;
    if (bin_valid !== 1'b1 || bin_out !== 64'(v)) begin
      tests_failed++;
      $display("FAIL reset_restart: got valid=%b out=%0d, want 1 %0d", bin_valid, bin_out, v);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    last_in = bcd_in;
  endtask

  task automatic test_random();
    logic [35:0] val, pre;
    longint unsigned v;
    bit e, ok;
    int hold;
    for (int it = 0; it < 24; it++) begin
      val = rand_bcd(1);
      while (val == last_in) val = rand_bcd(1);
      if ($urandom_range(0, 1) == 1) begin
        pre = rand_bcd(0);
        while (pre == last_in || pre == val) pre = rand_bcd(0);
        bcd_in = pre;
        tick($urandom_range(1, 15));
      end
      bcd_in = val;
      out_ready = 1'b0;
      ref_conv(val, v, e);
      tick(25);
      tests_run++;
      if (bin_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_early[%0d]: got valid=%b, want 0", it, bin_valid);
      end
      tick(1);
      tests_run++;
      if (e) begin
        if (bin_valid !== 1'b0 || digit_err !== 1'b1 || busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand_err[%0d]: in=%h got valid=%b err=%b busy=%b, want 0 1 0",
                   it, val, bin_valid, digit_err, busy);
        end
      end else begin
        ok = (bin_valid === 1'b1) && (bin_out === 64'(v)) && (digit_err === 1'b0);
        hold = $urandom_range(0, 3);
        for (int k = 0; k < hold; k++) begin
          tick(1);
          if (bin_valid !== 1'b1 || bin_out !== 64'(v)) ok = 0;
        end
        if (!ok) begin
          tests_failed++;
          $display("FAIL rand_result[%0d]: in=%h got valid=%b out=%0d err=%b, want 1 %0d 0",
                   it, val, bin_valid, bin_out, digit_err, v);
        end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tests_run++;
        if (bin_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand_handshake[%0d]: got valid=%b, want 0", it, bin_valid);
        end
      end
      last_in = val;
    end
  endtask

  initial begin
    test_reset();
    test_basic_123();
    test_max_hold();
    test_bounce();
    test_digit_err();
    test_change_in_hold();
    test_reset_mid_conv();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bcd_bin_seq.md
# bcd_bin_seq

Sequential BCD-to-binary converter between the keypad digit buffer and the primality tester. Watches the 9-digit packed BCD entry and waits until it has been stable for a fixed number of cycles. It then converts it to a 64-bit binary word, one digit per clock, most significant digit first. It presents the result to `is_prime` with a valid/ready handshake and flags non-decimal nibbles instead of passing garbage downstream.

## Interface

- `DIGITS`, 9: number of BCD digits in `bcd_in`
- `BIN_W`, 64: width of `bin_out`
- `STABLE_CYC`, 16: consecutive cycles `bcd_in` must hold before conversion starts (≥2)

- `clk`  in  1  system clock, single clock domain
- `rst`  in  1  asynchronous, active-low reset
- `bcd_in`  in  4*DIGITS  packed BCD, digit DIGITS-1 in MS nibble
- `out_ready`  in  1  downstream accepts `bin_out`
- `bin_out`  out  BIN_W  converted value, zero-extended
- `bin_valid`  out  1  `bin_out` holds a new, unaccepted result
- `digit_err`  out  1  last conversion hit a nibble > 9
- `busy`  out  1  high in WAIT, CONV and HOLD

## Operation

- Registers: `snap` (4*DIGITS), `cnt` (covers STABLE_CYC), `idx` (covers DIGITS), `acc` (BIN_W), `err`, `state`.
- Reset (async, `rst`=0): state IDLE, `snap`=0, `acc`=0, `cnt`=0, `idx`=0. Outputs `bin_out`=0, `bin_valid`=0, `digit_err`=0, `busy`=0.
- IDLE: if `bcd_in` != `snap`, then `snap`<=`bcd_in`, `cnt`<=0, go WAIT. An entry of all-zero after reset therefore triggers no conversion.
- WAIT: if `bcd_in` != `snap`, then `snap`<=`bcd_in` and `cnt`<=0 (restart). Else if `cnt`==STABLE_CYC-1, then `acc`<=0, `idx`<=DIGITS-1, `err`<=0, `digit_err`<=0, go CONV. Else `cnt`++.
- CONV: take digit d = `snap[4*idx+:4]`. Update `acc` <= `acc`*10 + d, computed as (`acc`<<3)+(`acc`<<1)+d, truncated to BIN_W. If d > 9, set `err`<=1; d is still added. At `idx`==0: if `err` (including the current digit), `digit_err`<=1 and go IDLE with `bin_out` unchanged. Otherwise `bin_out`<=final `acc`, `bin_valid`<=1, go HOLD. Else `idx`--.
- HOLD: `bin_valid` and `bin_out` stay stable until `out_ready`=1. On that edge, `bin_valid`<=0 and go IDLE.
- `bcd_in` changes during CONV or HOLD are ignored there. They are caught in IDLE because `snap` still holds the converted value.
- `digit_err` stays high until the next entry into CONV.
- Maximum legal input 999 999 999 < 2^30, so truncation never occurs for legal input with BIN_W ≥ 30.

## Timing

- Let edge E0 be the first edge at which IDLE sees `bcd_in` != `snap`, with `bcd_in` stable from then on. CONV is entered at edge E(STABLE_CYC). `bin_valid` rises after edge E(STABLE_CYC+DIGITS), which is 25 cycles with the defaults.
- Any `bcd_in` change in WAIT restarts the full STABLE_CYC window.
- `out_ready` high on the cycle `bin_valid` rises gives a 1-cycle valid pulse. The earliest next WAIT entry is the cycle after.
- `out_ready` is ignored outside HOLD. `bin_valid` never drops without a handshake, except on reset.
- Reset mid-WAIT, CONV or HOLD aborts immediately. All outputs go to reset values and any partial `acc` is discarded.

## Structure

- Shared package: state encoding (IDLE, WAIT, CONV, HOLD), defaults for DIGITS/BIN_W/STABLE_CYC, and the BCD digit-max constant 9.
- One sub-module: `mul10_add`. It is combinational, computes `acc`*10+d at BIN_W, and is reusable by other radix converters. The FSM and registers stay in `bcd_bin_seq`.

## Test plan

- `bcd_in`=0x000000123 held, `out_ready`=1 → after 25 cycles `bin_valid` pulses 1 cycle with `bin_out`=123, `digit_err`=0.
- `bcd_in`=0x999999999, `out_ready`=0 for 10 cycles after valid → `bin_out`=0x3B9AC9FF held stable. `bin_valid` stays high until `out_ready`, then drops next cycle.
- Bounce: 0x000000005 for 7 cycles, then 0x000000050 held → single result `bin_out`=50 at 25 cycles after the second change. No result for 5.
- `bcd_in`=0x0000000A1 → no `bin_valid`. `digit_err`=1 after 25 cycles. A following 0x000000042 clears `digit_err` at CONV entry and yields 42.
- Change `bcd_in` from 7 to 8 during HOLD (`out_ready`=0) → `bin_out`=7 stays valid. After the handshake a new conversion yields 8.
- Assert `rst`=0 mid-CONV → `bin_valid`=0, `busy`=0, `bin_out`=0 asynchronously. After release, the same held nonzero input converts normally from scratch.
